vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; replaces the fixed 640x480 sync driver.

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, active coordinates,
// line/frame strobes and frame counter, advancing one pixel per clk with pix_en.
module vga_timing_gen #(
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_ACTIVE  = 480,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   xpos,
    output logic [CNT_W-1:0]   ypos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_BLANK_C   = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_BLANK_C   = CNT_W'(V_BLANK);

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 ||
        64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_param_check
        $error("vga_timing_gen: porch/sync/active must be >= 1 and totals must fit CNT_W");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_act_nxt;
    logic             v_act_nxt;

    // Next counter position; equals the current one while pix_en is low.
    always_comb begin
        h_wrap    = (h_cnt == H_LAST);
        v_wrap    = (v_cnt == V_LAST);
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        if (pix_en) begin
            h_nxt = h_wrap ? '0 : h_cnt + CNT_W'(1);
            if (h_wrap) begin
                v_nxt = v_wrap ? '0 : v_cnt + CNT_W'(1);
            end
        end
        h_act_nxt = (h_nxt >= H_BLANK_C);
        v_act_nxt = (v_nxt >= V_BLANK_C);
    end

    // Outputs are decoded from the next position so they line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= (h_nxt >= H_SYNC_BEG && h_nxt < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (v_nxt >= V_SYNC_BEG && v_nxt < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
            de          <= h_act_nxt && v_act_nxt;
            xpos        <= (h_act_nxt && v_act_nxt) ? h_nxt - H_BLANK_C : '0;
            ypos        <= v_act_nxt ? v_nxt - V_BLANK_C : '0;
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en && h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny inverted-polarity
// raster on a second instance for frame-level, wrap and reset behaviour.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        pe_a;
    logic        pe_b;

    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0]  x_a, y_a;
    logic [15:0] fc_a;

    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [2:0]  x_b, y_b;
    logic [1:0]  fc_b;

    int n_cmp;
    int n_bad;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .xpos(x_a), .ypos(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .H_ACTIVE(4),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(3), .FRAME_W(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pe_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .xpos(x_b), .ypos(y_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        pe_a  = 1'b0;
        pe_b  = 1'b0;
        step(2);

        check("rst_hs_a", hs_a, 1);
        check("rst_vs_a", vs_a, 1);
        check("rst_de_a", de_a, 0);
        check("rst_x_a", x_a, 0);
        check("rst_y_a", y_a, 0);
        check("rst_ls_a", ls_a, 0);
        check("rst_fs_a", fs_a, 0);
        check("rst_fc_a", fc_a, 0);
        check("rst_hs_b", hs_b, 0);
        check("rst_vs_b", vs_b, 0);
        rst_n = 1'b1;

        // Default timing, line and vsync windows
        pe_a = 1'b1;
        step(15);    check("a_hs_h15", hs_a, 1);
        step(1);     check("a_hs_h16", hs_a, 0);
        step(95);    check("a_hs_h111", hs_a, 0);
        step(1);     check("a_hs_h112", hs_a, 1);
        step(687);   check("a_ls_h799", ls_a, 0);
        step(1);     check("a_ls_wrap", ls_a, 1);
        step(1);     check("a_ls_once", ls_a, 0);
        step(7198);  check("a_vs_l9end", vs_a, 1);
        step(1);     check("a_vs_l10", vs_a, 0);
        step(1599);  check("a_vs_l11end", vs_a, 0);
        step(1);     check("a_vs_l12", vs_a, 1);
        step(26559); check("a_de_h159", de_a, 0);
        step(1);     check("a_de_h160", de_a, 1);
                     check("a_x_h160", x_a, 0);
                     check("a_y_l45", y_a, 0);
        step(639);   check("a_x_h799", x_a, 639);

        // Stall: everything holds, then the wrap strobe is exactly one clk
        pe_a = 1'b0;
        step(3);     check("a_hold_x", x_a, 639);
                     check("a_hold_de", de_a, 1);
                     check("a_hold_ls", ls_a, 0);
        pe_a = 1'b1;
        step(1);     check("a_ls_l46", ls_a, 1);
                     check("a_de_l46", de_a, 0);
                     check("a_x_l46", x_a, 0);
                     check("a_y_l46", y_a, 1);
        pe_a = 1'b0;
        step(1);     check("a_ls_nostretch", ls_a, 0);
                     check("a_y_hold", y_a, 1);
                     check("a_fs_none", fs_a, 0);

        // Small raster: H_TOTAL 7, V_TOTAL 6, active-high syncs
        pe_b = 1'b1;
        step(1);     check("b_hs_h1", hs_b, 1);
        step(1);     check("b_hs_h2", hs_b, 0);
        step(4);     check("b_ls_h6", ls_b, 0);
        step(1);     check("b_ls_wrap", ls_b, 1);
                     check("b_vs_l1", vs_b, 1);
                     check("b_fs_l1", fs_b, 0);
        step(7);     check("b_vs_l2", vs_b, 0);
        step(10);    check("b_de_first", de_b, 1);
                     check("b_x_first", x_b, 0);
                     check("b_y_first", y_b, 0);
        step(17);    check("b_x_last", x_b, 3);
                     check("b_y_last", y_b, 2);
                     check("b_fs_pre", fs_b, 0);
        step(1);     check("b_fs_1", fs_b, 1);
                     check("b_ls_with_fs", ls_b, 1);
                     check("b_fc_1", fc_b, 1);
                     check("b_de_wrap", de_b, 0);
                     check("b_y_wrap", y_b, 0);

        // Toggled enable: frame takes twice the clocks, strobe still 1 clk
        for (int i = 0; i < 41; i++) begin
            pe_b = 1'b1; step(1);
            if (i == 0) check("b_tog_hs_on", hs_b, 1);
            pe_b = 1'b0; step(1);
            if (i == 0) check("b_tog_hs_hold", hs_b, 1);
        end
        check("b_tog_fs_pre", fs_b, 0);
        check("b_tog_fc_pre", fc_b, 1);
        pe_b = 1'b1; step(1);
        check("b_tog_fs", fs_b, 1);
        check("b_tog_fc", fc_b, 2);
        pe_b = 1'b0; step(1);
        check("b_tog_fs_width", fs_b, 0);
        check("b_tog_fc_hold", fc_b, 2);

        pe_b = 1'b1;
        step(42);    check("b_fc_3", fc_b, 3);
                     check("b_fs_3", fs_b, 1);
        step(41);    check("b_fc_3_hold", fc_b, 3);
        step(1);     check("b_fc_wrap", fc_b, 0);
                     check("b_fs_4", fs_b, 1);
        step(42);    check("b_fc_after_wrap", fc_b, 1);
        step(39);    check("b_mid_de", de_b, 1);
                     check("b_mid_x", x_b, 1);
                     check("b_mid_y", y_b, 2);

        // Asynchronous reset mid-frame
        rst_n = 1'b0;
        #1;
        check("ar_de_b", de_b, 0);
        check("ar_x_b", x_b, 0);
        check("ar_y_b", y_b, 0);
        check("ar_fc_b", fc_b, 0);
        check("ar_hs_b", hs_b, 0);
        check("ar_vs_b", vs_b, 0);
        check("ar_y_a", y_a, 0);
        check("ar_hs_a", hs_a, 1);
        check("ar_vs_a", vs_a, 1);
        step(1);
        rst_n = 1'b1;
        step(1);     check("ar_no_strobe", ls_b, 0);
        step(40);    check("ar_fs_pre", fs_b, 0);
        step(1);     check("ar_fs", fs_b, 1);
                     check("ar_fc", fc_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
